// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: ROM read port, redirect/halt controls and the decode handshake.
// The master modport is the fetch unit's view; slave is the surrounding ROM/decode/execute.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  imem_read_en;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_instruct;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  halt;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0] out_pc;

    modport master (
        output imem_read_en, imem_addr, out_valid, out_instr, out_pc,
        input  imem_instruct, redirect_valid, redirect_pc, halt, out_ready
    );

    modport slave (
        input  imem_read_en, imem_addr, out_valid, out_instr, out_pc,
        output imem_instruct, redirect_valid, redirect_pc, halt, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues ROM reads, pairs ROM words with their PC.
// Optional macro FETCH_SKID_EN: registered decode outputs backed by a 2-entry skid buffer.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  respValid_q, respValid_d;
    logic [ADDR_WIDTH-1:0] respPc_q, respPc_d;
    logic                  readEn;
    logic [ADDR_WIDTH-1:0] readAddr;
    logic                  slotFree;
    logic                  drainResp;

`ifdef FETCH_SKID_EN
    logic [DATA_WIDTH-1:0] skidInstr_q [2];
    logic [DATA_WIDTH-1:0] skidInstr_d [2];
    logic [ADDR_WIDTH-1:0] skidPc_q [2];
    logic [ADDR_WIDTH-1:0] skidPc_d [2];
    logic [1:0]            skidCount_q, skidCount_d;
    logic                  outValid_q, outValid_d;
    logic [DATA_WIDTH-1:0] outInstr_q, outInstr_d;
    logic [ADDR_WIDTH-1:0] outPc_q, outPc_d;
    logic                  outLoad;

    // The in-flight word always lands in the skid, so reserve its entry before issuing again.
    assign slotFree  = ({1'b0, skidCount_q} + {2'b00, respValid_q}) < 3'd2;
    assign drainResp = 1'b1;
`else
    assign slotFree  = !respValid_q || bus.out_ready;
    assign drainResp = bus.out_ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            respValid_q <= 1'b0;
            respPc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            respValid_q <= respValid_d;
            respPc_q    <= respPc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        respValid_d = respValid_q && !drainResp;
        respPc_d    = respPc_q;
        readEn      = 1'b0;
        readAddr    = pc_q;

        case (state_q)
            BOOT: begin
                state_d = bus.halt ? HALTED : RUN;
            end
            RUN: begin
                if (!bus.halt && slotFree) begin
                    readEn      = 1'b1;
                    respPc_d    = pc_q;
                    respValid_d = 1'b1;
                    pc_d        = pc_q + 1'b1;
                end
                state_d = bus.halt ? HALTED : RUN;
            end
            HALTED: begin
                state_d = bus.halt ? HALTED : RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // A redirect flushes the in-flight word and, if fetch is live, reads the target at once.
        if (bus.redirect_valid) begin
            readEn      = 1'b0;
            readAddr    = pc_q;
            respValid_d = 1'b0;
            pc_d        = bus.redirect_pc;
            if (state_q == RUN && !bus.halt) begin
                readEn      = 1'b1;
                readAddr    = bus.redirect_pc;
                respPc_d    = bus.redirect_pc;
                respValid_d = 1'b1;
                pc_d        = bus.redirect_pc + 1'b1;
            end
        end
    end

    assign bus.imem_read_en = readEn && !rst;
    assign bus.imem_addr    = rst ? '0 : readAddr;

`ifdef FETCH_SKID_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            skidInstr_q <= '{default: '0};
            skidPc_q    <= '{default: '0};
            skidCount_q <= '0;
            outValid_q  <= 1'b0;
            outInstr_q  <= '0;
            outPc_q     <= '0;
        end else begin
            skidInstr_q <= skidInstr_d;
            skidPc_q    <= skidPc_d;
            skidCount_q <= skidCount_d;
            outValid_q  <= outValid_d;
            outInstr_q  <= outInstr_d;
            outPc_q     <= outPc_d;
        end
    end

    always_comb begin
        skidInstr_d = skidInstr_q;
        skidPc_d    = skidPc_q;
        skidCount_d = skidCount_q;
        outValid_d  = outValid_q;
        outInstr_d  = outInstr_q;
        outPc_d     = outPc_q;
        outLoad     = !outValid_q || bus.out_ready;

        if (outLoad) begin
            outValid_d = 1'b0;
            outInstr_d = '0;
            outPc_d    = '0;
            if (skidCount_q != 2'd0) begin
                outValid_d     = 1'b1;
                outInstr_d     = skidInstr_q[0];
                outPc_d        = skidPc_q[0];
                skidInstr_d[0] = skidInstr_q[1];
                skidPc_d[0]    = skidPc_q[1];
                skidCount_d    = skidCount_q - 2'd1;
            end else if (respValid_q) begin
                outValid_d = 1'b1;
                outInstr_d = bus.imem_instruct;
                outPc_d    = respPc_q;
            end
        end

        // Queue the arriving word unless it went straight into the output register.
        if (respValid_q && !(outLoad && skidCount_q == 2'd0)) begin
            skidInstr_d[skidCount_d[0]] = bus.imem_instruct;
            skidPc_d[skidCount_d[0]]    = respPc_q;
            skidCount_d                 = skidCount_d + 2'd1;
        end

        if (bus.redirect_valid) begin
            skidCount_d = '0;
            outValid_d  = 1'b0;
            outInstr_d  = '0;
            outPc_d     = '0;
        end
    end

    assign bus.out_valid = outValid_q && !rst;
    assign bus.out_instr = (outValid_q && !rst) ? outInstr_q : '0;
    assign bus.out_pc    = (outValid_q && !rst) ? outPc_q : '0;
`else
    logic outValid;

    // The ROM holds its output while read_en is low, so a stalled word stays on imem_instruct.
    assign outValid      = respValid_q && !bus.redirect_valid && !rst;
    assign bus.out_valid = outValid;
    assign bus.out_instr = outValid ? bus.imem_instruct : '0;
    assign bus.out_pc    = outValid ? respPc_q : '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a behavioural next-address/pending-word model.
module tb_fetch_unit;
    localparam int M_BOOT   = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALTED = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] romQ = '0;
    logic [15:0] rom2Q = '0;
    int          checks = 0;
    int          errors = 0;

    int mPc = 0;
    int mPending = -1;
    int mMode = M_BOOT;

    fetch_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();
    fetch_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus2 ();

    fetch_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RESET_PC(16'hFFFE)) dutWrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] romWord(input logic [15:0] a);
        case (a)
            16'd0:   return 16'h1111;
            16'd1:   return 16'h2222;
            16'd2:   return 16'h3333;
            16'd3:   return 16'h4444;
            default: return (a * 16'h9E37) ^ 16'h5A5A;
        endcase
    endfunction

    // Registered ROMs with one cycle of latency; output holds while read_en is low.
    always @(posedge clk) begin
        if (bus.imem_read_en) romQ <= romWord(bus.imem_addr);
        if (bus2.imem_read_en) rom2Q <= romWord(bus2.imem_addr);
    end
    assign bus.imem_instruct  = romQ;
    assign bus2.imem_instruct = rom2Q;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic h, input logic rv, input logic [15:0] rp);
        @(posedge clk);
        #1;
        rst                = r;
        bus.out_ready      = rdy;
        bus.halt           = h;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
    endtask

    task automatic expectAll(input string tag, input logic re, input logic [15:0] addr,
                             input logic v, input logic [15:0] instr, input logic [15:0] pc);
        #2;
        checkOutput({tag, ".read_en"}, 32'(bus.imem_read_en), 32'(re));
        checkOutput({tag, ".addr"},    32'(bus.imem_addr),    32'(addr));
        checkOutput({tag, ".valid"},   32'(bus.out_valid),    32'(v));
        checkOutput({tag, ".instr"},   32'(bus.out_instr),    32'(instr));
        checkOutput({tag, ".pc"},      32'(bus.out_pc),       32'(pc));
    endtask

    // Cycle model: a next-address counter, at most one pending word, and a boot/run/halted mode.
    always @(negedge clk) begin
        logic        expRead;
        logic        expValid;
        int          expAddr;
        int          expPc;
        logic [15:0] expInstr;
        int          nPc;
        int          nPending;
        int          nMode;
        int          rpc;

        rpc = int'(bus.redirect_pc);
        if (rst) begin
            expRead  = 1'b0;
            expAddr  = 0;
            expValid = 1'b0;
            expPc    = 0;
            expInstr = '0;
            nPc      = 0;
            nPending = -1;
            nMode    = M_BOOT;
        end else begin
            expValid = (mPending >= 0) && !bus.redirect_valid;
            expPc    = expValid ? mPending : 0;
            expInstr = expValid ? romWord(16'(mPending)) : 16'h0;
            expRead  = 1'b0;
            expAddr  = mPc;
            nPc      = mPc;
            nPending = mPending;
            if (bus.redirect_valid) begin
                nPending = -1;
                nPc      = rpc;
                if (mMode == M_RUN && !bus.halt) begin
                    expRead  = 1'b1;
                    expAddr  = rpc;
                    nPending = rpc;
                    nPc      = (rpc + 1) % 65536;
                end
            end else if (mMode == M_RUN && !bus.halt && (mPending < 0 || bus.out_ready)) begin
                expRead  = 1'b1;
                nPending = mPc;
                nPc      = (mPc + 1) % 65536;
            end else if (bus.out_ready) begin
                nPending = -1;
            end
            nMode = bus.halt ? M_HALTED : M_RUN;
        end

        checkOutput("model.read_en", 32'(bus.imem_read_en), 32'(expRead));
        checkOutput("model.addr",    32'(bus.imem_addr),    32'(expAddr));
        checkOutput("model.valid",   32'(bus.out_valid),    32'(expValid));
        checkOutput("model.instr",   32'(bus.out_instr),    32'(expInstr));
        checkOutput("model.pc",      32'(bus.out_pc),       32'(expPc));

        mPc      = nPc;
        mPending = nPending;
        mMode    = nMode;
    end

    initial begin
        logic        r;
        logic        rdy;
        logic        h;
        logic        rv;
        logic [15:0] rp;

        rst                 = 1'b1;
        bus.out_ready       = 1'b1;
        bus.halt            = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus2.out_ready      = 1'b1;
        bus2.halt           = 1'b0;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;

        $display("[TB] phase A: reset release and sequential stream");
        applyStimulus(1, 1, 0, 0, 16'h0);
        applyStimulus(1, 1, 0, 0, 16'h0);
        expectAll("A.reset", 0, 16'h0, 0, 16'h0, 16'h0);
        applyStimulus(0, 1, 0, 0, 16'h0);
        expectAll("A.boot", 0, 16'h0, 0, 16'h0, 16'h0);
        applyStimulus(0, 1, 0, 0, 16'h0);
        expectAll("A.first_issue", 1, 16'h0, 0, 16'h0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 0, 0, 16'h0);
            expectAll("A.seq", 1, 16'(k + 1), 1, romWord(16'(k)), 16'(k));
            checkOutput("A.wrap.valid", 32'(bus2.out_valid), 32'(1));
            checkOutput("A.wrap.pc", 32'(bus2.out_pc), 32'(16'(16'hFFFE + 16'(k))));
            checkOutput("A.wrap.instr", 32'(bus2.out_instr), 32'(romWord(16'(16'hFFFE + 16'(k)))));
        end

        $display("[TB] phase B: backpressure then redirect");
        applyStimulus(1, 1, 0, 0, 16'h0);
        applyStimulus(0, 1, 0, 0, 16'h0);
        applyStimulus(0, 1, 0, 0, 16'h0);
        applyStimulus(0, 1, 0, 0, 16'h0);
        expectAll("B.out0", 1, 16'h1, 1, 16'h1111, 16'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 16'h0);
            expectAll("B.stall", 0, 16'h2, 1, 16'h2222, 16'h1);
        end
        applyStimulus(0, 1, 0, 0, 16'h0);
        expectAll("B.release", 1, 16'h2, 1, 16'h2222, 16'h1);
        applyStimulus(0, 1, 0, 1, 16'h0100);
        expectAll("B.redirect", 1, 16'h0100, 0, 16'h0, 16'h0);
        applyStimulus(0, 1, 0, 0, 16'h0);
        expectAll("B.target", 1, 16'h0101, 1, romWord(16'h0100), 16'h0100);
        applyStimulus(0, 1, 0, 0, 16'h0);
        expectAll("B.target_next", 1, 16'h0102, 1, romWord(16'h0101), 16'h0101);

        $display("[TB] phase C: reset while stalled");
        applyStimulus(1, 1, 0, 0, 16'h0);
        applyStimulus(0, 1, 0, 0, 16'h0);
        applyStimulus(0, 1, 0, 0, 16'h0);
        applyStimulus(0, 1, 0, 0, 16'h0);
        applyStimulus(0, 0, 0, 0, 16'h0);
        expectAll("C.stalled", 0, 16'h2, 1, 16'h2222, 16'h1);
        applyStimulus(1, 0, 0, 0, 16'h0);
        expectAll("C.reset", 0, 16'h0, 0, 16'h0, 16'h0);
        applyStimulus(0, 0, 0, 0, 16'h0);
        expectAll("C.boot", 0, 16'h0, 0, 16'h0, 16'h0);
        applyStimulus(0, 1, 0, 0, 16'h0);
        applyStimulus(0, 1, 0, 0, 16'h0);
        expectAll("C.restart", 1, 16'h1, 1, 16'h1111, 16'h0);

        $display("[TB] phase D: halt mid-stream");
        applyStimulus(1, 1, 0, 0, 16'h0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 0, 16'h0);
        applyStimulus(0, 1, 1, 0, 16'h0);
        expectAll("D.halt_drain", 0, 16'h3, 1, 16'h3333, 16'h2);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 1, 0, 16'h0);
            expectAll("D.halted", 0, 16'h3, 0, 16'h0, 16'h0);
        end
        applyStimulus(0, 1, 0, 0, 16'h0);
        expectAll("D.unhalt", 0, 16'h3, 0, 16'h0, 16'h0);
        applyStimulus(0, 1, 0, 0, 16'h0);
        expectAll("D.resume", 1, 16'h3, 0, 16'h0, 16'h0);
        applyStimulus(0, 1, 0, 0, 16'h0);
        expectAll("D.resume_out", 1, 16'h4, 1, 16'h4444, 16'h3);

        $display("[TB] phase E: randomized traffic");
        h = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) h = ~h;
            if ($urandom_range(0, 3) == 0) rp = 16'hFFFC + 16'($urandom_range(0, 3));
            else rp = 16'($urandom);
            applyStimulus(r, rdy, h, rv, rp);
        end

        applyStimulus(0, 1, 0, 0, 16'h0);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
